// File: rtl/sle_bank_ctrl.sv
// Sequencer/arbiter for a WIDTH-bit SLE flip-flop bank: shares the bank between two
// writers, issues SLn/SD synchronous clears, verifies each write by Q readback.
// Optional macro SLE_BANK_RR_EN selects round-robin arbitration (fixed priority otherwise).
module sle_bank_ctrl #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] SD_VAL     = '0,
  parameter int unsigned      CLR_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             CLR_REQ,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] BANK_Q,
  output logic             ACK0,
  output logic             ACK1,
  output logic             BANK_EN,
  output logic             BANK_SLn,
  output logic [WIDTH-1:0] BANK_SD,
  output logic [WIDTH-1:0] BANK_D,
  output logic             BUSY,
  output logic             ERR
);

  localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_WRITE, ST_VERIFY} state_e;

  state_e            state_q, state_d;
  logic              clr_pend_q, clr_pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic [WIDTH-1:0]  bank_d_q, bank_d_d;
  logic [1:0]        ack_q, ack_d;
  logic              en_q, en_d;
  logic              sln_q, sln_d;
  logic [WIDTH-1:0]  sd_q, sd_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [1:0]            req;
  logic [1:0][WIDTH-1:0] d_vec;
  logic                  win;

  assign req   = {REQ1, REQ0};
  assign d_vec = {D1, D0};

`ifdef SLE_BANK_RR_EN
  // Pointer names the port that wins the next tie; it flips away from every grant.
  logic ptr_q, ptr_d;

  always_comb begin
    win = (&req) ? ptr_q : req[1];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win = ~req[0];
  end
`endif

  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q | CLR_REQ;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    bank_d_d   = bank_d_q;
    err_d      = err_q;
`ifdef SLE_BANK_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A same-cycle CLR_REQ counts as pending, so clears beat writes.
        if (clr_pend_q | CLR_REQ) begin
          state_d    = ST_CLEAR;
          clr_pend_d = 1'b0;
          cnt_d      = CW'(CLR_CYCLES - 1);
        end else if (|req) begin
          state_d  = ST_WRITE;
          gnt_d    = win;
          bank_d_d = d_vec[win];
`ifdef SLE_BANK_RR_EN
          ptr_d    = ~win;
`endif
        end
      end
      ST_CLEAR: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WRITE: begin
        state_d = ST_VERIFY;
      end
      ST_VERIFY: begin
        // Bank captured BANK_D at the edge that entered this state.
        if (BANK_Q != bank_d_q) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    en_d   = (state_d == ST_CLEAR) || (state_d == ST_WRITE);
    sln_d  = (state_d != ST_CLEAR);
    sd_d   = SD_VAL;
    busy_d = (state_d != ST_IDLE);
    ack_d  = '0;
    if (state_d == ST_VERIFY) ack_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      clr_pend_q <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      bank_d_q   <= '0;
      ack_q      <= '0;
      en_q       <= 1'b0;
      sln_q      <= 1'b1;
      sd_q       <= SD_VAL;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      bank_d_q   <= bank_d_d;
      ack_q      <= ack_d;
      en_q       <= en_d;
      sln_q      <= sln_d;
      sd_q       <= sd_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign ACK0     = ack_q[0];
  assign ACK1     = ack_q[1];
  assign BANK_EN  = en_q;
  assign BANK_SLn = sln_q;
  assign BANK_SD  = sd_q;
  assign BANK_D   = bank_d_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule
